// File: rtl/dds_lane_combiner.sv
// -----------------------------------------------------------------------------
// dds_lane_combiner
// Combines the eight sin lanes and eight cos lanes of the DDS array into one
// sin and one cos sample. The path is a five-stage registered pipeline:
// lane capture with per-lane gating, a three-level adder tree, and then
// round/saturate into the output register.
//
// Ports:
//   clk      - sample clock
//   rst      - asynchronous active-high reset
//   in_val   - lane data valid
//   lane_en  - per-lane enable (bit i gates sin lane i and cos lane i)
//   sin_in   - packed sin lanes, lane i at [i*IN_W +: IN_W], two's complement
//   cos_in   - packed cos lanes, same packing
//   ovf_clr  - synchronous clear of the sticky overflow flags
//   sin_out  - combined sin sample (OUT_W, signed)
//   cos_out  - combined cos sample (OUT_W, signed)
//   out_val  - output valid, in_val delayed by 5 cycles
//   sin_ovf  - sticky flag: sin saturation has occurred
//   cos_ovf  - sticky flag: cos saturation has occurred
//   hdrm_ok  - both outputs keep a spare sign bit (MSB == MSB-1)
//
// Optional build macro DDS_COMB_CLIPCNT_EN adds sin_clip_cnt / cos_clip_cnt.
// These are 16-bit saturating counters of valid clipped samples, and they are
// cleared by ovf_clr.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module dds_lane_combiner #(
  parameter int IN_W  = 26,
  parameter int OUT_W = 16,
  parameter int SHIFT = 13
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_val,
  input  logic [7:0]             lane_en,
  input  logic [8*IN_W-1:0]      sin_in,
  input  logic [8*IN_W-1:0]      cos_in,
  input  logic                   ovf_clr,
  output logic [OUT_W-1:0]       sin_out,
  output logic [OUT_W-1:0]       cos_out,
  output logic                   out_val,
  output logic                   sin_ovf,
  output logic                   cos_ovf,
`ifdef DDS_COMB_CLIPCNT_EN
  output logic [15:0]            sin_clip_cnt,
  output logic [15:0]            cos_clip_cnt,
`endif
  output logic                   hdrm_ok
);

  localparam int SUM_W = IN_W + 3;
  localparam int RND_W = IN_W + 4;

  // Rounding offset and saturation limits. They are built at RND_W bits so
  // every comparison is done between operands of the same signed width.
  localparam logic signed [RND_W-1:0] RND_ADD =
    {{(RND_W-SHIFT){1'b0}}, 1'b1, {(SHIFT-1){1'b0}}};
  localparam logic signed [RND_W-1:0] MAX_V =
    {{(RND_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [RND_W-1:0] MIN_V =
    {{(RND_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  // Round half-up, shift right arithmetically, then saturate.
  // The return value is {clipped, sample}.
  function automatic logic [OUT_W:0] round_sat(input logic [SUM_W-1:0] s);
    logic signed [RND_W-1:0] ext;
    logic signed [RND_W-1:0] r;
    ext = $signed({s[SUM_W-1], s}) + RND_ADD;
    r   = ext >>> SHIFT;
    if (r > MAX_V)      return {1'b1, MAX_V[OUT_W-1:0]};
    else if (r < MIN_V) return {1'b1, MIN_V[OUT_W-1:0]};
    else                return {1'b0, r[OUT_W-1:0]};
  endfunction

  logic [IN_W-1:0]   r_sin1 [8];
  logic [IN_W-1:0]   r_cos1 [8];
  logic [IN_W:0]     r_sin2 [4];
  logic [IN_W:0]     r_cos2 [4];
  logic [IN_W+1:0]   r_sin3 [2];
  logic [IN_W+1:0]   r_cos3 [2];
  logic [SUM_W-1:0]  r_sin4;
  logic [SUM_W-1:0]  r_cos4;
  logic              r_v1, r_v2, r_v3, r_v4;

  logic [OUT_W:0]    w_sin_rs;
  logic [OUT_W:0]    w_cos_rs;
  logic              w_sin_clip;
  logic              w_cos_clip;

  // Stage 1: capture lanes. A disabled lane is forced to zero here, so an
  // enable change stays aligned with the data it gates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        r_sin1[i] <= {IN_W{1'b0}};
        r_cos1[i] <= {IN_W{1'b0}};
      end
      r_v1 <= 1'b0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        r_sin1[i] <= lane_en[i] ? sin_in[i*IN_W +: IN_W] : {IN_W{1'b0}};
        r_cos1[i] <= lane_en[i] ? cos_in[i*IN_W +: IN_W] : {IN_W{1'b0}};
      end
      r_v1 <= in_val;
    end
  end

  // Stages 2-4: sign-extended adder tree. Each level grows by one bit, so no
  // level can overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < 4; j++) begin
        r_sin2[j] <= {(IN_W+1){1'b0}};
        r_cos2[j] <= {(IN_W+1){1'b0}};
      end
      for (int k = 0; k < 2; k++) begin
        r_sin3[k] <= {(IN_W+2){1'b0}};
        r_cos3[k] <= {(IN_W+2){1'b0}};
      end
      r_sin4 <= {SUM_W{1'b0}};
      r_cos4 <= {SUM_W{1'b0}};
      r_v2   <= 1'b0;
      r_v3   <= 1'b0;
      r_v4   <= 1'b0;
    end else begin
      for (int j = 0; j < 4; j++) begin
        r_sin2[j] <= {r_sin1[2*j][IN_W-1], r_sin1[2*j]} +
                     {r_sin1[2*j+1][IN_W-1], r_sin1[2*j+1]};
        r_cos2[j] <= {r_cos1[2*j][IN_W-1], r_cos1[2*j]} +
                     {r_cos1[2*j+1][IN_W-1], r_cos1[2*j+1]};
      end
      for (int k = 0; k < 2; k++) begin
        r_sin3[k] <= {r_sin2[2*k][IN_W], r_sin2[2*k]} +
                     {r_sin2[2*k+1][IN_W], r_sin2[2*k+1]};
        r_cos3[k] <= {r_cos2[2*k][IN_W], r_cos2[2*k]} +
                     {r_cos2[2*k+1][IN_W], r_cos2[2*k+1]};
      end
      r_sin4 <= {r_sin3[0][IN_W+1], r_sin3[0]} + {r_sin3[1][IN_W+1], r_sin3[1]};
      r_cos4 <= {r_cos3[0][IN_W+1], r_cos3[0]} + {r_cos3[1][IN_W+1], r_cos3[1]};
      r_v2   <= r_v1;
      r_v3   <= r_v2;
      r_v4   <= r_v3;
    end
  end

  // Stage 5 combinational part: round and saturate the tree outputs.
  always_comb begin
    w_sin_rs   = round_sat(r_sin4);
    w_cos_rs   = round_sat(r_cos4);
    w_sin_clip = r_v4 & w_sin_rs[OUT_W];
    w_cos_clip = r_v4 & w_cos_rs[OUT_W];
  end

  // Output register. Samples and headroom update only on valid; out_val
  // follows the pipeline valid unconditionally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sin_out <= {OUT_W{1'b0}};
      cos_out <= {OUT_W{1'b0}};
      out_val <= 1'b0;
      hdrm_ok <= 1'b1;
    end else begin
      out_val <= r_v4;
      if (r_v4) begin
        sin_out <= w_sin_rs[OUT_W-1:0];
        cos_out <= w_cos_rs[OUT_W-1:0];
        hdrm_ok <= (w_sin_rs[OUT_W-1] == w_sin_rs[OUT_W-2]) &&
                   (w_cos_rs[OUT_W-1] == w_cos_rs[OUT_W-2]);
      end
    end
  end

  // Sticky overflow flags. A clip in the same cycle as ovf_clr wins, so
  // a clip event is never lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sin_ovf <= 1'b0;
      cos_ovf <= 1'b0;
    end else begin
      if (w_sin_clip)   sin_ovf <= 1'b1;
      else if (ovf_clr) sin_ovf <= 1'b0;
      if (w_cos_clip)   cos_ovf <= 1'b1;
      else if (ovf_clr) cos_ovf <= 1'b0;
    end
  end

`ifdef DDS_COMB_CLIPCNT_EN
  // Saturating clip counters. A clear that coincides with a clip restarts
  // the count at 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sin_clip_cnt <= 16'd0;
      cos_clip_cnt <= 16'd0;
    end else begin
      if (ovf_clr)
        sin_clip_cnt <= {15'd0, w_sin_clip};
      else if (w_sin_clip && (sin_clip_cnt != 16'hFFFF))
        sin_clip_cnt <= sin_clip_cnt + 16'd1;
      if (ovf_clr)
        cos_clip_cnt <= {15'd0, w_cos_clip};
      else if (w_cos_clip && (cos_clip_cnt != 16'hFFFF))
        cos_clip_cnt <= cos_clip_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dds_lane_combiner.sv
`timescale 1ns/1ps
module tb_dds_lane_combiner;

  localparam int IN_W  = 26;
  localparam int OUT_W = 16;
  localparam int SHIFT = 13;

  logic                clk = 1'b0;
  logic                rst;
  logic                in_val;
  logic [7:0]          lane_en;
  logic [8*IN_W-1:0]   sin_in;
  logic [8*IN_W-1:0]   cos_in;
  logic                ovf_clr;
  logic [OUT_W-1:0]    sin_out;
  logic [OUT_W-1:0]    cos_out;
  logic                out_val;
  logic                sin_ovf;
  logic                cos_ovf;
  logic                hdrm_ok;
`ifdef DDS_COMB_CLIPCNT_EN
  logic [15:0]         sin_clip_cnt;
  logic [15:0]         cos_clip_cnt;
`endif

  logic signed [IN_W-1:0] sl [8];
  logic signed [IN_W-1:0] cl [8];

  int tests = 0;
  int fails = 0;

  always #2.5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      sin_in[i*IN_W +: IN_W] = sl[i];
      cos_in[i*IN_W +: IN_W] = cl[i];
    end
  end

  dds_lane_combiner #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT)) dut (
    .clk(clk), .rst(rst), .in_val(in_val), .lane_en(lane_en),
    .sin_in(sin_in), .cos_in(cos_in), .ovf_clr(ovf_clr),
    .sin_out(sin_out), .cos_out(cos_out), .out_val(out_val),
    .sin_ovf(sin_ovf), .cos_ovf(cos_ovf),
`ifdef DDS_COMB_CLIPCNT_EN
    .sin_clip_cnt(sin_clip_cnt), .cos_clip_cnt(cos_clip_cnt),
`endif
    .hdrm_ok(hdrm_ok)
  );

  // ---------------- reference model ----------------
  typedef struct {
    bit          v;
    logic [15:0] so;
    logic [15:0] co;
    bit          ssat;
    bit          csat;
  } entry_t;

  entry_t      pipe[$];
  bit          m_val, m_hdrm, m_sovf, m_covf;
  logic [15:0] m_sin, m_cos;
  int          m_scnt, m_ccnt;

  // Round half-up (floor of (S + 2^(SHIFT-1)) / 2^SHIFT), then clamp to the output range.
  function automatic void ref_out(input longint s, output logic [15:0] o, output bit sat);
    longint r;
    r = (s + (longint'(1) <<< (SHIFT - 1))) >>> SHIFT;
    sat = 1'b0;
    if (r > 32767) begin
      r = 32767;
      sat = 1'b1;
    end else if (r < -32768) begin
      r = -32768;
      sat = 1'b1;
    end
    o = 16'(r);
  endfunction

  task automatic model_reset();
    pipe.delete();
    for (int i = 0; i < 4; i++) pipe.push_back('{1'b0, 16'd0, 16'd0, 1'b0, 1'b0});
    m_val = 0; m_sin = 16'd0; m_cos = 16'd0; m_hdrm = 1; m_sovf = 0; m_covf = 0;
    m_scnt = 0; m_ccnt = 0;
  endtask

  task automatic model_step();
    entry_t e;
    entry_t o;
    longint s;
    longint c;
    s = 0;
    c = 0;
    for (int i = 0; i < 8; i++) begin
      if (lane_en[i]) begin
        s += longint'(sl[i]);
        c += longint'(cl[i]);
      end
    end
    e.v = in_val;
    ref_out(s, e.so, e.ssat);
    ref_out(c, e.co, e.csat);
    pipe.push_back(e);
    o = pipe.pop_front();
    m_val = o.v;
    if (o.v) begin
      m_sin  = o.so;
      m_cos  = o.co;
      m_hdrm = (o.so[15] == o.so[14]) && (o.co[15] == o.co[14]);
    end
    if (o.v && o.ssat) m_sovf = 1; else if (ovf_clr) m_sovf = 0;
    if (o.v && o.csat) m_covf = 1; else if (ovf_clr) m_covf = 0;
    if (ovf_clr) begin
      m_scnt = (o.v && o.ssat) ? 1 : 0;
      m_ccnt = (o.v && o.csat) ? 1 : 0;
    end else begin
      if (o.v && o.ssat && m_scnt < 65535) m_scnt++;
      if (o.v && o.csat && m_ccnt < 65535) m_ccnt++;
    end
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic check_all();
    check("out_val", {31'd0, out_val}, {31'd0, m_val});
    check("sin_out", {{16{sin_out[15]}}, sin_out}, {{16{m_sin[15]}}, m_sin});
    check("cos_out", {{16{cos_out[15]}}, cos_out}, {{16{m_cos[15]}}, m_cos});
    check("hdrm_ok", {31'd0, hdrm_ok}, {31'd0, m_hdrm});
    check("sin_ovf", {31'd0, sin_ovf}, {31'd0, m_sovf});
    check("cos_ovf", {31'd0, cos_ovf}, {31'd0, m_covf});
`ifdef DDS_COMB_CLIPCNT_EN
    check("sin_clip_cnt", {16'd0, sin_clip_cnt}, 32'(m_scnt));
    check("cos_clip_cnt", {16'd0, cos_clip_cnt}, 32'(m_ccnt));
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic set_all(input int sv, input int cv);
    for (int i = 0; i < 8; i++) begin
      sl[i] = IN_W'(sv);
      cl[i] = IN_W'(cv);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; in_val = 1'b0; lane_en = 8'h00; ovf_clr = 1'b0;
    set_all(0, 0);
    model_reset();
    #1;
    check_all();
    check("reset_hdrm_one", {31'd0, hdrm_ok}, 32'd1);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    ticks(2);

    // Nominal: +2^20 sin / -2^20 cos on all lanes -> +/-1024.
    lane_en = 8'hFF; in_val = 1'b1;
    set_all(1 << 20, -(1 << 20));
    ticks(6);
    check("nominal_sin", {{16{sin_out[15]}}, sin_out}, 32'd1024);
    check("nominal_cos", {{16{cos_out[15]}}, cos_out}, -32'sd1024);

    // Rounding boundaries on lane 0 only.
    set_all(0, 0); sl[0] = 26'sd4096;  ticks(5);
    check("round_4096", {{16{sin_out[15]}}, sin_out}, 32'd1);
    sl[0] = 26'sd4095;                  ticks(5);
    check("round_4095", {{16{sin_out[15]}}, sin_out}, 32'd0);
    sl[0] = -26'sd4097;                 ticks(5);
    check("round_m4097", {{16{sin_out[15]}}, sin_out}, -32'sd1);

    // Saturation: sin clips high, cos lands exactly on the negative limit.
    set_all((1 << 25) - 1, -(1 << 25)); ticks(5);
    check("sat_sin", {16'd0, sin_out}, 32'h7FFF);
    check("sat_cos", {16'd0, cos_out}, 32'h8000);
    check("sat_sin_ovf", {31'd0, sin_ovf}, 32'd1);
    check("sat_cos_ovf", {31'd0, cos_ovf}, 32'd0);
    check("sat_hdrm", {31'd0, hdrm_ok}, 32'd0);
    set_all(0, 0); ticks(5);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    check("ovf_cleared", {31'd0, sin_ovf}, 32'd0);
    ticks(2);

    // Lane gating: switch enables for one cycle and expect a clean step 1024 -> 512.
    set_all(1 << 20, 1 << 20); ticks(6);
    lane_en = 8'h0F; ticks(4);
    check("gate_before", {{16{sin_out[15]}}, sin_out}, 32'd1024);
    tick();
    check("gate_after", {{16{sin_out[15]}}, sin_out}, 32'd512);
    lane_en = 8'h00; ticks(5);
    check("gate_none", {{16{sin_out[15]}}, sin_out}, 32'd0);

    // Valid gaps.
    lane_en = 8'hFF;
    in_val = 1'b1; set_all(3000, -5000); tick();
    in_val = 1'b0; set_all(9999, 9999);  tick();
    in_val = 1'b1; set_all(-7000, 100);  tick();
    in_val = 1'b1; set_all(123, 45678);  tick();
    in_val = 1'b0; ticks(6);

    // Mid-stream asynchronous reset.
    in_val = 1'b1; set_all(1 << 20, -(1 << 20)); ticks(7);
    @(posedge clk); model_step();
    #1 rst = 1'b1;
    #0.5;
    model_reset();
    check("async_rst_val", {31'd0, out_val}, 32'd0);
    check("async_rst_sin", {16'd0, sin_out}, 32'd0);
    check("async_rst_cos", {16'd0, cos_out}, 32'd0);
    #0.5 rst = 1'b0;
    @(negedge clk); check_all();
    in_val = 1'b0; ticks(3);
    in_val = 1'b1; ticks(6);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      in_val  = ($urandom_range(0, 3) != 0);
      lane_en = 8'($urandom);
      ovf_clr = ($urandom_range(0, 15) == 0);
      for (int i = 0; i < 8; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          sl[i] = IN_W'($urandom);
          cl[i] = IN_W'($urandom);
        end else begin
          sl[i] = IN_W'(int'($urandom_range(0, 2097152)) - 1048576);
          cl[i] = IN_W'(int'($urandom_range(0, 2097152)) - 1048576);
        end
      end
      tick();
    end
    ovf_clr = 1'b0;

`ifdef DDS_COMB_CLIPCNT_EN
    // Long clip run to reach the counter ceiling, then clear during a clip.
    in_val = 1'b1; lane_en = 8'hFF; set_all((1 << 25) - 1, 0);
    ticks(70000);
    check("clipcnt_sat", {16'd0, sin_clip_cnt}, 32'h0000FFFF);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    check("clipcnt_clr_clip", {16'd0, sin_clip_cnt}, 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dds_lane_combiner.md
Name: dds_lane_combiner

Overview:
- Sits directly downstream of the 8-lane DDS array.
- Sums the eight 26-bit sin lanes and eight 26-bit cos lanes through a registered adder tree, with per-lane enable.
- Rounds and saturates each sum to a 16-bit sample for the DAC/mixer path.
- Flags clipping and sign-bit headroom loss on the output.

Parameters:
- IN_W, 26: signed width of each input lane. Lane count is fixed at 8.
- OUT_W, 16: signed output sample width.
- SHIFT, 13: right shift applied to the 29-bit lane sum before saturation. Legal range is 1..(IN_W+3-1).

Ports:
- clk  in  1  sample clock (200 MHz)
- rst  in  1  asynchronous, active-high reset
- in_val  in  1  lane data valid
- lane_en  in  8  per-lane enable; bit i gates sin lane i and cos lane i
- sin_in  in  8*IN_W  packed sin lanes, lane i at [i*IN_W +: IN_W], two's complement
- cos_in  in  8*IN_W  packed cos lanes, same packing
- ovf_clr  in  1  synchronous clear of the sticky overflow flags
- sin_out  out  OUT_W  combined sin sample
- cos_out  out  OUT_W  combined cos sample
- out_val  out  1  output valid
- sin_ovf  out  1  sticky: sin saturation has occurred
- cos_ovf  out  1  sticky: cos saturation has occurred
- hdrm_ok  out  1  registered with the output: (sin_out[MSB]==sin_out[MSB-1]) & (cos_out[MSB]==cos_out[MSB-1])

Behaviour:
- Reset:
  - Asynchronous, active-high on rst.
  - All pipeline registers, sin_out, cos_out, out_val, sin_ovf and cos_ovf clear to 0.
  - hdrm_ok resets to 1.
  - Reset asserted mid-stream discards all in-flight samples. The first out_val after release is 5 cycles after the first in_val sampled high.
- Pipeline (fixed latency 5 cycles, in_val to out_val):
  - Stage 1: register each lane. A disabled lane (lane_en[i]=0) registers as 0. in_val is registered alongside.
  - Stage 2: four pairwise sums, IN_W+1 bits, sign-extended.
  - Stage 3: two sums, IN_W+2 bits.
  - Stage 4: one sum S, IN_W+3 = 29 bits.
  - Stage 5: rounding, saturation and output register.
- Rounding:
  - R = (S + 2^(SHIFT-1)) >>> SHIFT.
  - Arithmetic shift; the addition is at IN_W+4 bits so it cannot overflow.
  - Result is round-half-up.
- Saturation:
  - If R > 2^(OUT_W-1)-1, output 2^(OUT_W-1)-1.
  - If R < -2^(OUT_W-1), output -2^(OUT_W-1).
  - Otherwise output R[OUT_W-1:0].
- Valid handling:
  - The valid bit travels with its data.
  - When in_val=0 the stage still advances. out_val follows in_val exactly, delayed 5 cycles.
  - sin_out and cos_out update only when the stage-5 valid is 1 and hold otherwise.
- Overflow flags:
  - sin_ovf/cos_ovf set on any valid sample that saturates, and remain set.
  - ovf_clr clears them in the next cycle.
  - If ovf_clr coincides with a saturating valid sample, the set wins and the flag stays 1.
- hdrm_ok updates with sin_out/cos_out; it is evaluated on the saturated output.
- lane_en is sampled at stage 1 together with the data. A change to lane_en affects the output exactly 5 cycles later, with no glitch samples.
- Output with lane_en=0x00 and in_val=1 is 0.

Optional Feature:
- Macro: DDS_COMB_CLIPCNT_EN.
- When defined:
  - Adds outputs sin_clip_cnt and cos_clip_cnt, 16 bits each.
  - Each counts valid saturating samples and holds at 0xFFFF (saturating).
  - Both counters reset to 0 on rst and clear on ovf_clr. A coincident clip leaves the count at 1.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- All lanes enabled, every sin lane = 2^20, every cos lane = -2^20, in_val=1 held -> after 5 cycles out_val=1, sin_out=1024, cos_out=-1024, no ovf, hdrm_ok=1.
- Rounding: lane0 sin=4096 and others 0 -> sin_out=1; lane0 sin=4095 -> sin_out=0; lane0 sin=-4097 -> sin_out=-1.
- Saturation: all sin lanes = 2^25-1 -> sin_out=32767, sin_ovf=1, hdrm_ok=0. All cos lanes = -2^25 -> cos_out=-32768, cos_ovf stays 0. Pulse ovf_clr with zero input -> sin_ovf=0 the cycle after.
- Lane gating: all lanes 2^20, switch lane_en from 0xFF to 0x0F in one cycle -> outputs 1024 then exactly 512 from the 5th cycle after the switch, no intermediate values.
- Valid gaps and reset: in_val pattern 1,0,1,1 -> identical out_val pattern 5 cycles later, outputs holding during the gap. Assert rst mid-stream for 1 ns (asynchronous) -> all outputs 0 immediately, out_val stays low until 5 cycles after the next in_val.
- (DDS_COMB_CLIPCNT_EN) 70000 consecutive saturating sin samples -> sin_clip_cnt=0xFFFF. ovf_clr coincident with a clip -> sin_clip_cnt=1.
